alu_flag_unit: RTL and testbench
================================

// Module: alu_flag_unit
// PURPOSE
//  Execute-stage ALU directly upstream of the NZCV flag register: computes the result and condition
//  flags for one operation per request and drives the flag register's d/en inputs.
//  ADD/SUB/AND/ORR/EOR/PASS complete in one cycle. MUL is an iterative shift-add taking WIDTH cycles.
//  A ready/start/done handshake lets the control FSM stall for multi-cycle ops.
// PARAMETERS
//  WIDTH  64  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  reset      in   1      synchronous, active-high
//  start      in   1      request; accepted only on a cycle where ready=1
//  op         in   3      000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 11x PASS (result=b)
//  set_flags  in   1      request flag-register update for this op (sampled at accept)
//  a          in   WIDTH  operand A (sampled at accept)
//  b          in   WIDTH  operand B (sampled at accept)
//  ready      out  1      unit can accept start this cycle
//  done       out  1      one-cycle pulse: result/flags_d valid
//  result     out  WIDTH  registered result; held until next done
//  flags_d    out  4      {N,Z,C,V} (bit3=N .. bit0=V); wires to flag register d
//  flags_en   out  1      pulse coincident with done when set_flags was 1; wires to flag register en
// BEHAVIOUR
//  Reset: state=IDLE, result=0, flags_d=0, done=0, flags_en=0, counter=0. Any in-flight MUL aborts, no done.
//   ready=0 while reset is high, 1 on the first cycle after release.
//  States: IDLE (ready=1), MUL (ready=0).
//  IDLE, start & op!=MUL at cycle T: result/flags_d registered at T+1 edge; done=1 during T+1; stay IDLE.
//   Back-to-back accepts give one done per cycle.
//  IDLE, start & op==MUL at T: capture a, b, set_flags; clear product; go MUL.
//   Do one iteration per cycle for WIDTH cycles (counter 0..WIDTH-1).
//   The last iteration registers result; done=1 during cycle T+WIDTH+1.
//   Return to IDLE, so ready=1 in that same cycle; a new start is accepted then.
//  start while ready=0: ignored (dropped), no side effects. Operand changes after accept: ignored.
//  done, flags_en: high exactly one cycle per accepted op, else 0.
//   flags_en = done & captured set_flags.
//  flags_d updates on every done regardless of set_flags; the flag register holds its own copy unless flags_en=1.
//  Arithmetic (all modulo 2^WIDTH):
//   ADD: result=a+b; C=carry out of bit WIDTH-1; V=(a[MSB]==b[MSB]) & (result[MSB]!=a[MSB]).
//   SUB: result=a+~b+1; C=1 iff a>=b unsigned (no borrow); V=(a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]).
//   AND/ORR/EOR/PASS/MUL: C=0, V=0. MUL result = low WIDTH bits of unsigned product (same as signed low half).
//   All ops: N=result[WIDTH-1]; Z=(result==0).
//  Simultaneous done and new start in IDLE: both honoured; the next done follows one cycle later (single-cycle op).
// TESTING
//  1. ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1, set_flags=1 -> next cycle: done=1,
//     result=64'h8000_0000_0000_0000, flags_d=4'b1001, flags_en=1.
//  2. SUB a=5, b=5 -> result=0, flags_d=4'b0110.
//     SUB a=3, b=5 -> result=64'hFFFF_FFFF_FFFF_FFFE, flags_d=4'b1000.
//  3. MUL a=3, b=64'hFFFF_FFFF_FFFF_FFFF at T -> ready=0 for T+1..T+64; done only at T+65;
//     result=64'hFFFF_FFFF_FFFF_FFFD, flags_d=4'b1000.
//     start pulses during T+1..T+64 produce no extra done.
//  4. Back-to-back AND(0xF0,0x0F), ORR(0xF0,0x0F), EOR(0xFF,0xFF) on consecutive cycles ->
//     three consecutive done pulses; results 0, 0xFF, 0; flags_d 4'b0100, 4'b0000, 4'b0100.
//  5. ADD a=1, b=2, set_flags=0 -> done=1, result=3, flags_d=4'b0000, flags_en=0.
//  6. reset high at MUL iteration 20 for one cycle -> no done ever for that op;
//     result=0, flags_d=0; ready=1 the cycle after release.

Source files
------------

// File: rtl/alu_flag_unit.sv
// Execute-stage ALU feeding the NZCV flag register.
// Single-cycle ADD/SUB/AND/ORR/EOR/PASS; iterative shift-add MUL over WIDTH cycles.
module alu_flag_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_d,
  output logic             flags_en
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic             sf_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] mul_acc;
  logic             mul_last;

  assign ready = (state == S_IDLE) && !reset;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    // Carry out of a + ~b + 1 is the no-borrow flag, i.e. a >= b unsigned.
    diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = b;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b100:  alu_res = a ^ b;
      default: alu_res = b;
    endcase
  end

  always_comb begin
    mul_acc  = prod + (mplier[0] ? mcand : '0);
    mul_last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      sf_q     <= 1'b0;
      result   <= '0;
      flags_d  <= '0;
      done     <= 1'b0;
      flags_en <= 1'b0;
    end else begin
      done     <= 1'b0;
      flags_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == 3'b101) begin
              mcand  <= a;
              mplier <= b;
              prod   <= '0;
              sf_q   <= set_flags;
              cnt    <= '0;
              state  <= S_MUL;
            end else begin
              result   <= alu_res;
              flags_d  <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
              done     <= 1'b1;
              flags_en <= set_flags;
            end
          end
        end
        S_MUL: begin
          prod   <= mul_acc;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            result   <= mul_acc;
            flags_d  <= {mul_acc[WIDTH-1], mul_acc == '0, 2'b00};
            done     <= 1'b1;
            flags_en <= sf_q;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboard bench for alu_flag_unit: expectations queued at accept, compared at done.
module tb_alu_flag_unit;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic         set_flags;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags_d;
  logic         flags_en;

  alu_flag_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .set_flags (set_flags),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .flags_d   (flags_d),
    .flags_en  (flags_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         fen;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic sf, input int c,
                                 input string tag);
    exp_t e;
    logic [W-1:0] r;
    logic cf, vf;
    cf = 1'b0;
    vf = 1'b0;
    case (o)
      3'd0: begin
        r  = x + y;
        cf = (r < x);
        vf = ($signed(x) >= 0) == ($signed(y) >= 0) && (($signed(r) >= 0) != ($signed(x) >= 0));
      end
      3'd1: begin
        r  = x - y;
        cf = (x >= y);
        vf = (($signed(x) >= 0) != ($signed(y) >= 0)) && (($signed(r) >= 0) != ($signed(x) >= 0));
      end
      3'd2:    r = x & y;
      3'd3:    r = x | y;
      3'd4:    r = x ^ y;
      3'd5:    r = x * y;
      default: r = y;
    endcase
    e.res = r;
    e.fl  = {r[W-1], (r == 0), cf, vf};
    e.fen = sf;
    e.cyc = c + ((o == 3'd5) ? (W + 1) : 1);
    e.tag = tag;
    return e;
  endfunction

  // Drive one request shortly after a rising edge; queue an expectation only if accepted.
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic sf, input string tag, output bit acc);
    @(posedge clk);
    #1;
    start     = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    set_flags = sf;
    acc       = ready;
    if (ready) sb.push_back(model(o, x, y, sf, cyc, tag));
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
  endtask

  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (!done && flags_en) check("stray_flags_en", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_cycle"}, W'(cyc), W'(e.cyc));
          check({e.tag, "_res"}, result, e.res);
          check({e.tag, "_flags"}, W'(flags_d), W'(e.fl));
          check({e.tag, "_flags_en"}, W'(flags_en), W'(e.fen));
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        check({sb[0].tag, "_missing_done"}, W'(cyc), W'(sb[0].cyc));
        void'(sb.pop_front());
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      idle_cycle();
      n++;
    end
    check("drain_timeout", W'(sb.size()), 0);
  endtask

  initial begin
    bit acc;
    reset = 1'b1; start = 1'b0; op = '0; set_flags = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", W'(ready), 0);
    check("reset_done", W'(done), 0);
    check("reset_result", result, 0);
    check("reset_flags", W'(flags_d), 0);
    reset = 1'b0;
    #1;
    check("ready_after_release", W'(ready), 1);
    mon_on = 1'b1;

    send(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, "add_ovf", acc);
    idle_cycle();
    send(3'd1, 64'd5, 64'd5, 1'b1, "sub_eq", acc);
    send(3'd1, 64'd3, 64'd5, 1'b1, "sub_borrow", acc);
    idle_cycle();
    drain(10);

    // MUL with start pulses while busy: all must be dropped
    send(3'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "mul_neg", acc);
    check("mul_accept", W'(acc), 1);
    for (int i = 1; i <= int'(W); i++) begin
      send(3'd0, 64'd11, 64'd22, 1'b1, "dropped", acc);
      check("mul_busy_ready", W'(acc), 0);
    end
    // done cycle: ready returns and a new request is honoured at once
    send(3'd2, 64'hF0, 64'h0F, 1'b1, "and_after_mul", acc);
    check("ready_on_mul_done", W'(acc), 1);
    send(3'd3, 64'hF0, 64'h0F, 1'b1, "orr_b2b", acc);
    send(3'd4, 64'hFF, 64'hFF, 1'b0, "eor_b2b", acc);
    send(3'd0, 64'd1, 64'd2, 1'b0, "add_nosf", acc);
    send(3'd6, 64'd9, 64'h8000_0000_0000_0000, 1'b1, "pass", acc);
    send(3'd7, 64'd9, 64'd0, 1'b1, "pass7_zero", acc);
    send(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, "add_carry", acc);
    send(3'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, "sub_ovf", acc);
    idle_cycle();
    drain(10);

    for (int k = 0; k < 12; k++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      send(ro, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()), "rand", acc);
      if (ro == 3'd5) begin
        idle_cycle();
        drain(W + 10);
      end
    end
    idle_cycle();
    drain(W + 10);

    // Reset at MUL iteration 20 aborts it silently
    send(3'd5, 64'd7, 64'd9, 1'b1, "mul_aborted", acc);
    start = 1'b0;
    repeat (20) idle_cycle();
    reset = 1'b1;
    #1;
    check("ready_in_reset", W'(ready), 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_ready", W'(ready), 1);
    check("abort_result", result, 0);
    check("abort_flags", W'(flags_d), 0);
    check("abort_done", W'(done), 0);
    repeat (W + 5) idle_cycle();
    send(3'd1, 64'd10, 64'd4, 1'b1, "sub_post_reset", acc);
    idle_cycle();
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
